// File: rtl/ntr_pkg.sv
`default_nettype none
// ============================================================================
// ntr_pkg : shared types and sizes for the cartridge command capture block
// Rev 1.0 : initial release
// ============================================================================
package ntr_pkg;

    localparam int NTR_CMD_BYTES = 8;
    localparam int NTR_BUS_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DUMMY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ntr_state_e;

    // Counter width able to hold 0..n-1 (never narrower than one bit).
    function automatic int ntr_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ntr_sync.sv
`default_nettype none
// ============================================================================
// ntr_sync : multi-bit flop chain synchronizer with a programmable reset value
// Rev 1.0 : initial release
// ============================================================================
module ntr_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ntr_cmd_capture.sv
`default_nettype none
// ============================================================================
// ntr_cmd_capture : captures the fixed-length command sent on the cartridge bus
// Rev 1.0 : initial release
// ============================================================================
module ntr_cmd_capture
    import ntr_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DUMMY_CLKS  = 1,
    parameter int CMD_BYTES   = NTR_CMD_BYTES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ntr_clk,
    input  logic                         ntr_cs1,
    input  logic [NTR_BUS_W-1:0]         ntr_data,
    output logic [NTR_BUS_W*CMD_BYTES-1:0] cmd,
    output logic                         cmd_valid,
    output logic                         cmd_abort,
    output logic                         busy
);

    localparam int CMD_W = NTR_BUS_W * CMD_BYTES;
    localparam int DCW   = ntr_cnt_w(DUMMY_CLKS);
    localparam int BCW   = ntr_cnt_w(CMD_BYTES);

    localparam logic [DCW-1:0] DUMMY_LAST = DCW'((DUMMY_CLKS > 0) ? DUMMY_CLKS - 1 : 0);
    localparam logic [BCW-1:0] BYTE_LAST  = BCW'(CMD_BYTES - 1);
    localparam ntr_state_e     START_ST   = (DUMMY_CLKS == 0) ? ST_SHIFT : ST_DUMMY;

    // Control pair idles with chip-select deasserted so reset never fakes a fall.
    logic [1:0]           ctl_s;
    logic [NTR_BUS_W-1:0] data_s;
    logic                 clk_s;
    logic                 cs1_s;

    ntr_sync #(
        .WIDTH   (2),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (2'b10)
    ) u_sync_ctl (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({ntr_cs1, ntr_clk}),
        .q     (ctl_s)
    );

    ntr_sync #(
        .WIDTH   (NTR_BUS_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ('0)
    ) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ntr_data),
        .q     (data_s)
    );

    assign cs1_s = ctl_s[1];
    assign clk_s = ctl_s[0];

    logic                 clk_prev_q,  clk_prev_d;
    logic                 cs1_prev_q,  cs1_prev_d;
    logic                 clk_rise_q,  clk_rise_d;
    logic                 cs1_rise_q,  cs1_rise_d;
    logic                 cs1_fall_q,  cs1_fall_d;
    logic [NTR_BUS_W-1:0] data_q,      data_d;
    ntr_state_e           state_q,     state_d;
    logic [DCW-1:0]       dummy_cnt_q, dummy_cnt_d;
    logic [BCW-1:0]       byte_cnt_q,  byte_cnt_d;
    logic [CMD_W-1:0]     shift_q,     shift_d;
    logic [CMD_W-1:0]     cmd_q,       cmd_d;
    logic                 valid_pend_q, valid_pend_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic                 cmd_abort_q, cmd_abort_d;
    logic [CMD_W-1:0]     shift_nx;

    always_comb begin
        // Edge strobes are registered; data is registered alongside to stay aligned.
        clk_prev_d   = clk_s;
        cs1_prev_d   = cs1_s;
        clk_rise_d   = clk_s & ~clk_prev_q;
        cs1_rise_d   = cs1_s & ~cs1_prev_q;
        cs1_fall_d   = ~cs1_s & cs1_prev_q;
        data_d       = data_s;

        state_d      = state_q;
        dummy_cnt_d  = dummy_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        cmd_d        = cmd_q;
        valid_pend_d = 1'b0;
        cmd_valid_d  = valid_pend_q;
        cmd_abort_d  = 1'b0;
        shift_nx     = (shift_q << NTR_BUS_W) | CMD_W'(data_q);

        case (state_q)
            ST_IDLE: begin
                if (cs1_fall_q) begin
                    state_d     = START_ST;
                    dummy_cnt_d = '0;
                    byte_cnt_d  = '0;
                end
            end
            default: begin
                // A chip-select rise outranks a same-cycle bus clock rise.
                if (cs1_rise_q) begin
                    state_d     = ST_IDLE;
                    cmd_abort_d = (state_q != ST_DONE);
                end else if (cs1_fall_q) begin
                    state_d     = START_ST;
                    dummy_cnt_d = '0;
                    byte_cnt_d  = '0;
                end else if (clk_rise_q) begin
                    if (state_q == ST_DUMMY) begin
                        if (dummy_cnt_q == DUMMY_LAST) begin
                            state_d    = ST_SHIFT;
                            byte_cnt_d = '0;
                        end else begin
                            dummy_cnt_d = dummy_cnt_q + DCW'(1);
                        end
                    end else if (state_q == ST_SHIFT) begin
                        shift_d = shift_nx;
                        if (byte_cnt_q == BYTE_LAST) begin
                            cmd_d        = shift_nx;
                            valid_pend_d = 1'b1;
                            state_d      = ST_DONE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BCW'(1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev_q   <= 1'b0;
            cs1_prev_q   <= 1'b1;
            clk_rise_q   <= 1'b0;
            cs1_rise_q   <= 1'b0;
            cs1_fall_q   <= 1'b0;
            data_q       <= '0;
            state_q      <= ST_IDLE;
            dummy_cnt_q  <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            cmd_q        <= '0;
            valid_pend_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_abort_q  <= 1'b0;
        end else begin
            clk_prev_q   <= clk_prev_d;
            cs1_prev_q   <= cs1_prev_d;
            clk_rise_q   <= clk_rise_d;
            cs1_rise_q   <= cs1_rise_d;
            cs1_fall_q   <= cs1_fall_d;
            data_q       <= data_d;
            state_q      <= state_d;
            dummy_cnt_q  <= dummy_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            cmd_q        <= cmd_d;
            valid_pend_q <= valid_pend_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_abort_q  <= cmd_abort_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_abort = cmd_abort_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ntr_cmd_capture.sv
`default_nettype none
// ============================================================================
// tb_ntr_cmd_capture : scoreboard bench for the cartridge command capture block
// Rev 1.0 : initial release
// ============================================================================
module tb_ntr_cmd_capture;

    localparam int SYNC_STAGES = 2;

    logic        clk;
    logic        rst_n;
    logic        ntr_clk;
    logic        ntr_cs1;
    logic [7:0]  ntr_data;
    logic [63:0] cmd;
    logic        cmd_valid;
    logic        cmd_abort;
    logic        busy;

    ntr_cmd_capture #(
        .SYNC_STAGES (SYNC_STAGES),
        .DUMMY_CLKS  (1),
        .CMD_BYTES   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ntr_clk   (ntr_clk),
        .ntr_cs1   (ntr_cs1),
        .ntr_data  (ntr_data),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_abort (cmd_abort),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_abort;
        logic [63:0] cmd;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_cmd = '0;
    logic        valid_prev = 1'b0;
    logic        abort_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (cmd_valid || cmd_abort)) begin
            chk("pulse_excl", 64'(cmd_valid & cmd_abort), 64'd0);
            chk("pulse_width", 64'((cmd_valid & valid_prev) | (cmd_abort & abort_prev)), 64'd0);
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 64'(cmd_valid | cmd_abort), 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("pulse_kind", 64'(cmd_abort), 64'(sb_e.is_abort));
                chk("pulse_cmd", cmd, sb_e.cmd);
            end
        end
        valid_prev = cmd_valid;
        abort_prev = cmd_abort;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cs_low();
        @(negedge clk);
        ntr_cs1 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        ntr_cs1 = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Called on a negedge; returns on a negedge with ntr_clk low again.
    task automatic send_byte(input logic [7:0] b, input bit measure);
        ntr_data = b;
        repeat (4) @(negedge clk);
        ntr_clk = 1'b1;
        if (measure) begin
            @(posedge clk);
            for (int i = 1; i <= SYNC_STAGES + 2; i++) begin
                @(posedge clk);
                #1;
                chk("latency", 64'(cmd_valid), 64'(i == SYNC_STAGES + 2));
            end
            repeat (2) @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        ntr_clk = 1'b0;
    endtask

    task automatic run_cmd(input logic [63:0] c, input int nbytes, input bit measure);
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(c[63-8*i -: 8], measure && (i == nbytes - 1));
        end
    endtask

    task automatic push_exp(input bit is_abort, input logic [63:0] c);
        exp_t e;
        e.is_abort = is_abort;
        e.cmd      = c;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        repeat (6) @(negedge clk);
        chk(tag, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] c;
        rst_n    = 1'b0;
        ntr_clk  = 1'b0;
        ntr_cs1  = 1'b1;
        ntr_data = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_cmd", cmd, 64'd0);
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_abort", 64'(cmd_abort), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Full command with latency measurement on the final byte
        exp_cmd = 64'hFF00000000000001;
        push_exp(1'b0, exp_cmd);
        cs_low();
        chk("t1_busy", 64'(busy), 64'd1);
        run_cmd(exp_cmd, 8, 1'b1);
        cs_high();
        drain("t1_drain");
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_cmd", cmd, exp_cmd);

        // Second command followed by extra bus clocks while selected
        exp_cmd = 64'hFF00000000000000;
        push_exp(1'b0, exp_cmd);
        cs_low();
        run_cmd(exp_cmd, 8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'($urandom), 1'b0);
        end
        chk("t2_busy_done", 64'(busy), 64'd1);
        cs_high();
        drain("t2_drain");
        chk("t2_cmd", cmd, exp_cmd);

        // Abort after three bytes
        push_exp(1'b1, exp_cmd);
        cs_low();
        run_cmd(64'h123456789ABCDEF0, 3, 1'b0);
        cs_high();
        drain("t3_drain");
        chk("t3_cmd", cmd, exp_cmd);

        // Reset in the middle of the shift phase
        cs_low();
        run_cmd(64'h0102030405060708, 5, 1'b0);
        rst_n   = 1'b0;
        ntr_cs1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_cmd", cmd, 64'd0);
        chk("t4_valid", 64'(cmd_valid), 64'd0);
        chk("t4_abort", 64'(cmd_abort), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        drain("t4_drain");
        exp_cmd = {$urandom, $urandom};
        push_exp(1'b0, exp_cmd);
        cs_low();
        run_cmd(exp_cmd, 8, 1'b0);
        cs_high();
        drain("t4b_drain");
        chk("t4b_cmd", cmd, exp_cmd);

        // Final bus clock and chip-select rise together
        c = 64'hDEADBEEFCAFEF00D;
        push_exp(1'b1, exp_cmd);
        cs_low();
        run_cmd(c, 7, 1'b0);
        ntr_data = c[7:0];
        repeat (4) @(negedge clk);
        ntr_clk = 1'b1;
        ntr_cs1 = 1'b1;
        repeat (6) @(negedge clk);
        ntr_clk = 1'b0;
        repeat (6) @(negedge clk);
        drain("t5_drain");
        chk("t5_cmd", cmd, exp_cmd);
        chk("t5_busy", 64'(busy), 64'd0);

        // Chip-select held low through reset release counts as a fall
        rst_n   = 1'b0;
        ntr_cs1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_busy", 64'(busy), 64'd1);
        exp_cmd = 64'h0011223344556677;
        push_exp(1'b0, exp_cmd);
        run_cmd(exp_cmd, 8, 1'b0);
        cs_high();
        drain("t6_drain");
        chk("t6_cmd", cmd, exp_cmd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
